// File: rtl/imem_loader.sv
// Instruction memory loader.
// A byte stream from a boot source fills a byte-wide instruction memory,
// starting at address 0. The fetch side reads a big-endian 32-bit word at
// any byte address, wrapping at the top of memory.
module imem_loader #(
  parameter int DEPTH = 512,
  parameter int AW    = 9
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [7:0]    byte_in,
  input  logic          byte_valid,
  input  logic          byte_last,
  output logic          byte_ready,
  input  logic [AW-1:0] rd_addr,
  output logic [31:0]   rd_data,
  output logic          busy,
  output logic          done,
  output logic [AW:0]   byte_count,
  output logic          overflow,
  output logic          misaligned
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t        state_reg;
  logic [AW-1:0] wr_addr_reg;
  logic [AW:0]   count_reg;
  logic          ready_reg;
  logic          busy_reg;
  logic          done_reg;
  logic          overflow_reg;
  logic          misaligned_reg;

  // Byte storage; deliberately has no reset so an aborted session keeps
  // whatever was already loaded.
  logic [7:0]    mem [DEPTH];

  logic          xfer;
  logic          at_end;
  logic [AW:0]   count_inc;

  // ready_reg is high only in LOAD, so it doubles as the write qualifier.
  assign xfer      = ready_reg && byte_valid;
  assign at_end    = (wr_addr_reg == AW'(DEPTH - 1));
  assign count_inc = count_reg + (AW+1)'(1);

  // Session control FSM with registered status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      wr_addr_reg    <= '0;
      count_reg      <= '0;
      ready_reg      <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      overflow_reg   <= 1'b0;
      misaligned_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          // A new session clears the previous session's results; any byte
          // presented alongside start is dropped because ready_reg is low.
          if (start) begin
            state_reg      <= LOAD;
            wr_addr_reg    <= '0;
            count_reg      <= '0;
            ready_reg      <= 1'b1;
            busy_reg       <= 1'b1;
            done_reg       <= 1'b0;
            overflow_reg   <= 1'b0;
            misaligned_reg <= 1'b0;
          end
        end
        LOAD: begin
          if (byte_valid) begin
            count_reg <= count_inc;
            if (byte_last || at_end) begin
              // Session ends: either the image said so, or memory is full.
              state_reg      <= DONE;
              ready_reg      <= 1'b0;
              busy_reg       <= 1'b0;
              done_reg       <= 1'b1;
              overflow_reg   <= !byte_last;
              misaligned_reg <= (count_inc[1:0] != 2'b00);
            end
            // Hold the address at the top instead of wrapping to 0.
            if (!at_end) begin
              wr_addr_reg <= wr_addr_reg + AW'(1);
            end
          end
        end
        default: begin
          state_reg <= IDLE;
          ready_reg <= 1'b0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  // Memory write port: one byte per accepted transfer.
  always_ff @(posedge clk) begin
    if (xfer) begin
      mem[wr_addr_reg] <= byte_in;
    end
  end

  // Four combinational read ports assemble the big-endian word; the AW-bit
  // address sum wraps naturally at the top of memory.
  for (genvar gi = 0; gi < 4; gi++) begin : g_rd
    logic [AW-1:0] addr;
    assign addr                   = rd_addr + AW'(gi);
    assign rd_data[31-8*gi -: 8]  = mem[addr];
  end

  assign byte_ready = ready_reg;
  assign busy       = busy_reg;
  assign done       = done_reg;
  assign byte_count = count_reg;
  assign overflow   = overflow_reg;
  assign misaligned = misaligned_reg;

endmodule
